// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a registered output stage and a
// per-register busy scoreboard for long-latency ops. Optional writeback bypass: WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqReady,
  input  logic                      issueValid,
  input  logic [ADDR_W-1:0]         issueAddr,
  output logic                      issueReady,
  input  logic [ADDR_W-1:0]         chkAddrA,
  input  logic [ADDR_W-1:0]         chkAddrB,
  output logic                      stallA,
  output logic                      stallB,
  output logic                      fwdValidA,
  output logic                      fwdValidB,
  output logic [DATA_W-1:0]         fwdDataA,
  output logic [DATA_W-1:0]         fwdDataB,
  output logic [ADDR_W-1:0]         addrWrite,
  output logic [DATA_W-1:0]         writeData,
  output logic                      writeReg
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int NREG  = 2 ** ADDR_W;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W:0]    cand;
  logic [PTR_W:0]    nxt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Handshake: a requester transfers on an edge where reqValid[i] & reqReady[i]; reqReady is
  // one-hot, depends on reqValid, and the requester must hold addr/data stable while valid.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    reqReady = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && reqValid[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
    if (found) reqReady[gnt_idx] = 1'b1;
    sel_addr = reqAddr[gnt_idx*ADDR_W +: ADDR_W];
    sel_data = reqData[gnt_idx*DATA_W +: DATA_W];
  end

  // A write pending in the output stage is suppressed while reset is high so it never commits.
  assign writeReg   = wr_q & ~rst;
  assign addrWrite  = addr_q;
  assign writeData  = data_q;
  assign issueReady = ~busy_q[issueAddr];

  always_comb begin
    ptr_d  = ptr_q;
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    nxt    = {1'b0, gnt_idx} + (PTR_W+1)'(1);
    if (found) begin
      ptr_d  = (nxt == (PTR_W+1)'(NUM_REQ)) ? '0 : nxt[PTR_W-1:0];
      wr_d   = (sel_addr != '0);
      addr_d = sel_addr;
      data_d = sel_data;
    end
    busy_d = busy_q;
    if (writeReg) busy_d[addr_q] = 1'b0;
    // Set after clear so a same-edge issue to the committing register stays pending.
    if (issueValid && issueReady && issueAddr != '0) busy_d[issueAddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwdValidA = writeReg && (addr_q == chkAddrA) && (chkAddrA != '0);
  assign fwdValidB = writeReg && (addr_q == chkAddrB) && (chkAddrB != '0);
  assign fwdDataA  = fwdValidA ? data_q : '0;
  assign fwdDataB  = fwdValidB ? data_q : '0;
`else
  assign fwdValidA = 1'b0;
  assign fwdValidB = 1'b0;
  assign fwdDataA  = '0;
  assign fwdDataB  = '0;
`endif

  assign stallA = busy_q[chkAddrA] & ~fwdValidA;
  assign stallB = busy_q[chkAddrB] & ~fwdValidB;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, all checked against a
// cycle-level reference model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    reqValid;
  logic [N*AW-1:0] reqAddr;
  logic [N*DW-1:0] reqData;
  logic [N-1:0]    reqReady;
  logic            issueValid;
  logic [AW-1:0]   issueAddr;
  logic            issueReady;
  logic [AW-1:0]   chkAddrA, chkAddrB;
  logic            stallA, stallB, fwdValidA, fwdValidB;
  logic [DW-1:0]   fwdDataA, fwdDataB;
  logic [AW-1:0]   addrWrite;
  logic [DW-1:0]   writeData;
  logic            writeReg;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady), .issueValid(issueValid), .issueAddr(issueAddr),
    .issueReady(issueReady), .chkAddrA(chkAddrA), .chkAddrB(chkAddrB), .stallA(stallA),
    .stallB(stallB), .fwdValidA(fwdValidA), .fwdValidB(fwdValidB), .fwdDataA(fwdDataA),
    .fwdDataB(fwdDataB), .addrWrite(addrWrite), .writeData(writeData), .writeReg(writeReg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int          m_ptr;
  bit          m_busy[32];
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (reqValid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wr = 0; m_addr = '0; m_data = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  // One clock: compare outputs mid-cycle, advance the model, then step past the edge.
  task automatic cycle();
    int          g;
    bit          wr_vis, iss_rdy, fa, fb, sa, sb;
    logic [31:0] exp_rdy, fda, fdb;
    @(negedge clk);
    g       = model_grant();
    exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
    wr_vis  = m_wr && !rst;
    iss_rdy = (issueAddr == 0) ? 1'b1 : !m_busy[issueAddr];
    fa      = BYPASS && wr_vis && m_addr == chkAddrA && chkAddrA != 0;
    fb      = BYPASS && wr_vis && m_addr == chkAddrB && chkAddrB != 0;
    fda     = fa ? m_data : 32'd0;
    fdb     = fb ? m_data : 32'd0;
    sa      = chkAddrA != 0 && m_busy[chkAddrA] && !fa;
    sb      = chkAddrB != 0 && m_busy[chkAddrB] && !fb;
    check_val("reqReady",   32'(reqReady),   exp_rdy);
    check_val("writeReg",   32'(writeReg),   32'(wr_vis));
    check_val("addrWrite",  32'(addrWrite),  32'(m_addr));
    check_val("writeData",  writeData,       m_data);
    check_val("issueReady", 32'(issueReady), 32'(iss_rdy));
    check_val("stallA",     32'(stallA),     32'(sa));
    check_val("stallB",     32'(stallB),     32'(sb));
    check_val("fwdValidA",  32'(fwdValidA),  32'(fa));
    check_val("fwdValidB",  32'(fwdValidB),  32'(fb));
    check_val("fwdDataA",   fwdDataA,        fda);
    check_val("fwdDataB",   fwdDataB,        fdb);
    if (rst) begin
      model_reset();
    end else begin
      if (wr_vis) m_busy[m_addr] = 0;
      if (issueValid && iss_rdy && issueAddr != 0) m_busy[issueAddr] = 1;
      if (g >= 0) begin
        m_ptr  = (g + 1) % N;
        m_wr   = (reqAddr[g*AW +: AW] != 0);
        m_addr = reqAddr[g*AW +: AW];
        m_data = reqData[g*DW +: DW];
      end else begin
        m_wr = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reqValid = '0; reqAddr = '0; reqData = '0;
    issueValid = 1'b0; issueAddr = '0; chkAddrA = '0; chkAddrB = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[i] = 1'b1;
    reqAddr[i*AW +: AW] = a;
    reqData[i*DW +: DW] = d;
  endtask

  initial begin
    model_reset();
    set_idle();
    rst = 1'b1;

    // Reset with all requesters active
    reqValid = '1;
    cycle(); cycle();
    rst = 1'b0;
    set_idle();
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    #1;
    check_val("rst_first_grant", 32'(reqReady), 32'd1);
    check_val("rst_writeReg",    32'(writeReg), 32'd0);

    // Round-robin fairness with all three held valid
    for (int i = 0; i < 6; i++) begin
      check_val("rr_grant", 32'(reqReady), 32'd1 << (i % 3));
      cycle();
    end
    set_idle();
    cycle(); cycle();

    // Scoreboard: issue 7, re-issue refused, requester 2 commits 7
    issueValid = 1'b1; issueAddr = 5'd7; chkAddrA = 5'd7;
    cycle();
    #1;
    check_val("sb_stall7", 32'(stallA), 32'(!BYPASS || 1'b1));
    check_val("sb_reissue_ready", 32'(issueReady), 32'd0);
    cycle();
    issueValid = 1'b0;
    set_req(2, 5'd7, 32'hDEAD);
    cycle();
    reqValid = '0;
    cycle(); cycle(); cycle();

    // Register 0 request and issue
    set_req(1, 5'd0, 32'h1234);
    issueValid = 1'b1; issueAddr = 5'd0; chkAddrB = 5'd0;
    cycle();
    set_idle();
    cycle();

    // Same-edge clear and set of register 5
    set_req(0, 5'd5, 32'h55);
    cycle();
    reqValid = '0;
    issueValid = 1'b1; issueAddr = 5'd5; chkAddrA = 5'd5;
    cycle();
    issueValid = 1'b0;
    #1;
    check_val("same_edge_stall5", 32'(stallA), 32'd1);
    cycle(); cycle();

    // Reset arriving the cycle after a grant
    set_idle();
    set_req(1, 5'd9, 32'h99);
    cycle();
    reqValid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle(); cycle();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 59) == 0);
      reqValid   = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        reqAddr[i*AW +: AW] = AW'($urandom_range(0, 9));
        reqData[i*DW +: DW] = $urandom;
      end
      issueValid = ($urandom_range(0, 2) == 0);
      issueAddr  = AW'($urandom_range(0, 9));
      chkAddrA   = AW'($urandom_range(0, 9));
      chkAddrB   = AW'($urandom_range(0, 9));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
